ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised PS/2 keyboard front end. Samples the raw PS/2 clock/data pins in the system clock domain and assembles 11-bit frames.
- Decodes make, break (F0) and extended (E0) sequences against a configurable table of NUM_KEYS scan codes.
- Per key, outputs a held flag, a saturating hold-time counter and a one-cycle press/release event.
- Sits between the board PS/2 pins and game/control logic; replaces the fixed six-button decoder.

Parameters:
- NUM_KEYS, 6, number of tracked keys (1..32).
- KEY_CODES, {9'h032,9'h01C,9'h174,9'h16B,9'h172,9'h175}, packed NUM_KEYS*9 bits. Entry i occupies bits [9i+8:9i]. Bit 8 = E0-extended, bits 7:0 = scan code. Default order: up, down, left, right, A, B.
- CNT_W, 16, hold counter width.
- TICK_DIV, 1, system clocks per hold-counter increment (>=1).
- TIMEOUT_CYCLES, 50000, idle system clocks after which a partial frame is discarded.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, reset, synchronous, active-high.
- ps2_clk_i, input, 1, raw PS/2 clock (asynchronous).
- ps2_data_i, input, 1, raw PS/2 data (asynchronous).
- key_down, output, NUM_KEYS, bit i = key i currently held.
- hold_cnt, output, NUM_KEYS*CNT_W, counter i at [CNT_W*i +: CNT_W].
- evt_valid, output, 1, one-cycle pulse on press/release of a tracked key.
- evt_idx, output, IDX_W = max(1, clog2(NUM_KEYS)), index of the event key.
- evt_make, output, 1, 1 = press, 0 = release; qualified by evt_valid.
- frame_err, output, 1, one-cycle pulse on a discarded frame.

Behaviour:
- Reset values: key_down=0, hold_cnt all 0, evt_valid=0, evt_idx=0, evt_make=0, frame_err=0. Synchronizers are set to 1. Bit counter = 0. Decoder state = IDLE. Prescaler = 0. Reset mid-frame or mid-sequence abandons it.
- Input sync: each of ps2_clk_i and ps2_data_i passes through a 2-flop synchronizer. A falling edge is registered-high then low on the synchronized clock. Data is sampled in the edge-detect cycle.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1). Bit counter runs 0..10.
  - On the 11th edge, byte_valid pulses in the following cycle and the counter returns to 0.
  - A start bit of 1 on edge 0 is ignored (counter stays 0).
- Timeout: with counter != 0 and no falling edge for TIMEOUT_CYCLES clocks, the counter clears and frame_err pulses.
- Decoder FSM, advanced on byte_valid only:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> lookup {0,byte} as make, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> lookup {1,byte} as make, -> IDLE.
  - BRK: any -> lookup {0,byte} as break, -> IDLE.
  - EXT_BRK: any -> lookup {1,byte} as break, -> IDLE.
- Lookup: the lowest matching index wins. No match -> no effect.
- Make of key i with key_down[i]=0: key_down[i]<=1, hold_cnt[i]<=0, evt pulse with make=1.
- Make of key i with key_down[i]=1 (typematic repeat): no change, no event.
- Break of key i with key_down[i]=1: key_down[i]<=0, evt pulse with make=0. hold_cnt[i] retains its final value.
- Break of a key not held: no change, no event.
- Latency: evt_valid and key_down update 1 cycle after byte_valid, i.e. 2 cycles after the 11th edge-detect cycle.
- Hold counting: a free-running prescaler counts 0..TICK_DIV-1. Its tick asserts when the count = TICK_DIV-1 (every cycle when TICK_DIV=1). On tick, each held key's counter increments and saturates at 2^CNT_W-1.
- Same-cycle make and tick for a key: the clear wins (counter = 0).
- Only one event can occur per byte, so evt outputs never collide.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a frame with even parity (parity computed over data+parity bit) or stop bit = 0 is dropped. No byte_valid is produced and frame_err pulses in the cycle byte_valid would have pulsed. Decoder state is unchanged.
- Undefined: parity and stop bits are ignored. frame_err is driven only by timeout.

Decomposition:
- Package ps2_pkg holds:
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_FRAME_BITS=11.
  - Decoder state enum {IDLE, EXT, BRK, EXT_BRK}.
  - Default KEY_CODES constant and named index constants KEY_UP..KEY_B.
- One sub-module, ps2_rx_frame, contains the synchronizers, edge detect, shift register, bit counter, timeout and parity check. It outputs byte, byte_valid and frame_err.
- The decoder FSM, lookup and counters stay in the top module.

Test Plan:
- Reset, then frame 0x1C (parity 0, stop 1) -> key_down=6'b010000, evt_valid pulse with idx=4, make=1, 2 cycles after the 11th edge. hold_cnt[4] reads 10 after 10 further cycles (TICK_DIV=1).
- Bytes E0,75 then E0,F0,75 -> press idx=0, then release idx=0. key_down[0] returns to 0 and hold_cnt[0] freezes.
- Frames 1C,1C,1C (typematic) -> exactly one evt_valid. hold_cnt[4] is not cleared by the repeats.
- CNT_W=4, TICK_DIV=3, hold A for 60 cycles -> hold_cnt[4] saturates at 15 and stays there.
- Send 5 bits then idle TIMEOUT_CYCLES+1 -> frame_err pulses once. A following full 0x32 frame decodes to idx=5, make=1.
- With PS2_PARITY_CHECK_EN defined, frame 0x1C with parity=1 -> frame_err pulse, no evt, key_down unchanged. Assert reset mid-sequence (after F0) -> next 0x1C is decoded as a make.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key tracker: framing bytes, decoder states, default key table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_A     = 4;
  localparam int KEY_B     = 5;

  // Entry i sits at [9i+8:9i]; bit 8 flags an E0-prefixed code.
  // Last element of the concatenation is entry 0 (up).
  localparam logic [6*9-1:0] PS2_DEFAULT_KEY_CODES =
    {9'h032, 9'h01C, 9'h174, 9'h16B, 9'h172, 9'h175};

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: 2-flop sync of clk/data, falling-edge detect, 11-bit frame assembly, idle timeout.
// Latency: byte_valid_o pulses the cycle after the edge-detect cycle of the stop bit.
// Backpressure: none; the PS/2 device cannot be stalled, every byte is a one-cycle pulse.
// Ports: clk/reset (sync, active-high), ps2_clk_i/ps2_data_i raw pins,
//        rx_byte_o (held until next frame), byte_valid_o, frame_err_o (one-cycle pulses).
// Build option PS2_PARITY_CHECK_EN: drop frames with bad odd parity or a low stop bit.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_prev_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            vld_q, vld_d, err_q, err_d;
  logic            fall, din;
`ifdef PS2_PARITY_CHECK_EN
  logic            par_q, par_d;
`endif

  // Falling edge: synchronized clock was high last cycle and is low now.
  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign din  = dat_sync_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idle_d    = idle_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high "start" bit is line noise; stay aligned on the next edge.
        if (!din) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q < LAST_BIT) begin
`ifdef PS2_PARITY_CHECK_EN
        par_d     = din;
`endif
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        bit_cnt_d = 4'd0;
`ifdef PS2_PARITY_CHECK_EN
        if ((^{shift_q, par_q}) && din) vld_d = 1'b1;
        else                            err_d = 1'b1;
`else
        vld_d = 1'b1;
`endif
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        idle_d    = '0;
        err_d     = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      idle_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idle_q     <= idle_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign rx_byte_o    = shift_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard key tracker: make/break/E0 decode against KEY_CODES, per-key held flag and hold counter.
// Latency: key_down/evt_* update 1 cycle after byte_valid (2 cycles after the stop-bit edge detect).
// Backpressure: none; events are one-cycle pulses, at most one per received byte.
// Ports: clk/reset (sync, active-high), ps2_clk_i/ps2_data_i raw pins, key_down[NUM_KEYS],
//        hold_cnt (counter i at [CNT_W*i +: CNT_W]), evt_valid/evt_idx/evt_make, frame_err.
// Build option PS2_PARITY_CHECK_EN (in ps2_rx_frame) enables parity/stop-bit rejection.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 6,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = PS2_DEFAULT_KEY_CODES,
  parameter int                    CNT_W          = 16,
  parameter int                    TICK_DIV       = 1,
  parameter int                    TIMEOUT_CYCLES = 50000,
  localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ps2_clk_i,
  input  logic                      ps2_data_i,
  output logic [NUM_KEYS-1:0]       key_down,
  output logic [NUM_KEYS*CNT_W-1:0] hold_cnt,
  output logic                      evt_valid,
  output logic [IDX_W-1:0]          evt_idx,
  output logic                      evt_make,
  output logic                      frame_err
);

  localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]          rx_byte;
  logic                rx_vld;
  dec_state_e          state_q, state_d;
  logic                lk_en, lk_ext, lk_brk, hit, prs, rel;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic                evt_valid_q, evt_valid_d, evt_make_q, evt_make_d;
  logic [IDX_W-1:0]    evt_idx_q, evt_idx_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (frame_err)
  );

  // Prefix decoder; a lookup is issued on the byte that completes a sequence.
  always_comb begin
    state_d = state_q;
    lk_en   = 1'b0;
    lk_ext  = 1'b0;
    lk_brk  = 1'b0;
    if (rx_vld) begin
      case (state_q)
        DEC_IDLE: begin
          if (rx_byte == PS2_EXT)      state_d = DEC_EXT;
          else if (rx_byte == PS2_BRK) state_d = DEC_BRK;
          else                         lk_en   = 1'b1;
        end
        DEC_EXT: begin
          if (rx_byte == PS2_BRK)      state_d = DEC_EXT_BRK;
          else if (rx_byte == PS2_EXT) state_d = DEC_EXT;
          else begin
            lk_en   = 1'b1;
            lk_ext  = 1'b1;
            state_d = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          lk_en   = 1'b1;
          lk_brk  = 1'b1;
          state_d = DEC_IDLE;
        end
        default: begin
          lk_en   = 1'b1;
          lk_ext  = 1'b1;
          lk_brk  = 1'b1;
          state_d = DEC_IDLE;
        end
      endcase
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == {lk_ext, rx_byte}) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Typematic repeats and breaks of unheld keys fall out of these qualifiers.
  assign prs = lk_en & hit & ~lk_brk & ~key_down_q[hit_idx];
  assign rel = lk_en & hit &  lk_brk &  key_down_q[hit_idx];

  always_comb begin
    key_down_d = key_down_q;
    if (prs) key_down_d[hit_idx] = 1'b1;
    if (rel) key_down_d[hit_idx] = 1'b0;
    evt_valid_d = prs | rel;
    evt_idx_d   = (prs | rel) ? hit_idx : evt_idx_q;
    evt_make_d  = prs ? 1'b1 : (rel ? 1'b0 : evt_make_q);
  end

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // A fresh press clears the counter even on a tick cycle.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (prs && (hit_idx == IDX_W'(i)))
        cnt_d[i] = '0;
      else if (tick && key_down_q[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DEC_IDLE;
      key_down_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      evt_make_q  <= 1'b0;
      pre_q       <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      evt_make_q  <= evt_make_d;
      pre_q       <= pre_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    hold_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) hold_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end

  assign key_down  = key_down_q;
  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign evt_make  = evt_make_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

  localparam int H  = 4;    // system clocks per PS/2 half period
  localparam int TO = 200;  // reduced timeout for simulation

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  logic [5:0]  key_down;
  logic [95:0] hold_cnt;
  logic        evt_valid;
  logic [2:0]  evt_idx;
  logic        evt_make;
  logic        frame_err;

  logic [5:0]  key_down2;
  logic [23:0] hold_cnt2;
  logic        evt_valid2;
  logic [2:0]  evt_idx2;
  logic        evt_make2;
  logic        frame_err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int ferr_cnt = 0;
  int f0;
  int press_cyc [6];
  int rel_val   [6];

  typedef struct packed {
    logic [2:0] idx;
    logic       make;
  } ev_t;
  ev_t exp_q[$];

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_dat),
    .key_down   (key_down),
    .hold_cnt   (hold_cnt),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_make   (evt_make),
    .frame_err  (frame_err)
  );

  // Narrow saturating counters, slow tick, and a duplicated 0x1C entry at index 5.
  ps2_key_tracker #(
    .KEY_CODES      ({9'h01C, 9'h01C, 9'h174, 9'h16B, 9'h172, 9'h175}),
    .CNT_W          (4),
    .TICK_DIV       (3),
    .TIMEOUT_CYCLES (TO)
  ) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_dat),
    .key_down   (key_down2),
    .hold_cnt   (hold_cnt2),
    .evt_valid  (evt_valid2),
    .evt_idx    (evt_idx2),
    .evt_make   (evt_make2),
    .frame_err  (frame_err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every event must match the oldest pending expectation.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (evt_valid) begin
        chk("evt_expected", 64'(exp_q.size() != 0), 64'd1);
        chk("evt_latency", 64'(cyc - last_fall_cyc), 64'd4);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("evt_idx", 64'(evt_idx), 64'(e.idx));
          chk("evt_make", 64'(evt_make), 64'(e.make));
          if (e.make) press_cyc[e.idx] = cyc;
          else        rel_val[e.idx]   = cyc - press_cyc[e.idx];
        end
      end
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~(^d)) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      ps2_dat = bits[b];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (b == 10) last_fall_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par = 1'b0);
    send_bits(mk_frame(d, bad_par), 11);
  endtask

  task automatic push(input logic [2:0] idx, input logic make);
    exp_q.push_back('{idx: idx, make: make});
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key_down", 64'(key_down), 64'd0);
    chk("rst_hold_cnt", 64'(hold_cnt[63:0] | hold_cnt[95:64]), 64'd0);
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_evt_idx", 64'(evt_idx), 64'd0);
    chk("rst_evt_make", 64'(evt_make), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Plain make of A (0x1C)
    push(3'd4, 1'b1);
    send_byte(8'h1C);
    chk("a_key_down", 64'(key_down), 64'b010000);
    chk("a_hold", 64'(hold_cnt[64 +: 16]), 64'(cyc - press_cyc[4]));
    chk("dup_lowest_idx", 64'(key_down2), 64'b010000);

    // Extended up: E0 75 press, E0 F0 75 release
    push(3'd0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h75);
    chk("up_key_down", 64'(key_down), 64'b010001);
    push(3'd0, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("up_rel_key_down", 64'(key_down), 64'b010000);
    chk("up_hold_final", 64'(hold_cnt[0 +: 16]), 64'(rel_val[0]));
    repeat (20) @(negedge clk);
    chk("up_hold_frozen", 64'(hold_cnt[0 +: 16]), 64'(rel_val[0]));
    chk("sat_hold_a", 64'(hold_cnt2[16 +: 4]), 64'd15);

    // Release A, then typematic 1C x3 gives a single press
    push(3'd4, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("a_rel_key_down", 64'(key_down), 64'b000000);
    push(3'd4, 1'b1);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    chk("typ_key_down", 64'(key_down), 64'b010000);
    chk("typ_hold", 64'(hold_cnt[64 +: 16]), 64'(cyc - press_cyc[4]));
    repeat (60) @(negedge clk);
    chk("sat_hold_stays", 64'(hold_cnt2[16 +: 4]), 64'd15);

    // Break of an unheld key and an unknown code: no events
    send_byte(8'hF0);
    send_byte(8'h6B);
    send_byte(8'h15);
    chk("nop_key_down", 64'(key_down), 64'b010000);

    // Partial frame, then timeout
    f0 = ferr_cnt;
    send_bits(mk_frame(8'h55, 1'b0), 5);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_err", 64'(ferr_cnt - f0), 64'd1);
    push(3'd5, 1'b1);
    send_byte(8'h32);
    chk("b_key_down", 64'(key_down), 64'b110000);

    // Bad-parity frame of A while A is released
    push(3'd4, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    f0 = ferr_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_byte(8'h1C, 1'b1);
    chk("par_err", 64'(ferr_cnt - f0), 64'd1);
    chk("par_key_down", 64'(key_down), 64'b100000);
`else
    push(3'd4, 1'b1);
    send_byte(8'h1C, 1'b1);
    chk("par_err", 64'(ferr_cnt - f0), 64'd0);
    chk("par_key_down", 64'(key_down), 64'b110000);
`endif

    // Reset after F0 abandons the break sequence
    send_byte(8'hF0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_key_down", 64'(key_down), 64'd0);
    chk("mid_rst_hold", 64'(hold_cnt[64 +: 16]), 64'd0);
    push(3'd4, 1'b1);
    send_byte(8'h1C);
    chk("post_rst_make", 64'(key_down), 64'b010000);

    repeat (10) @(negedge clk);
    chk("events_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
